// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand-A forwarding pre-decode and load-use stall detection.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned ALU_A_OP_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_data_T,
  input  logic [DATA_W-1:0]     id_data_SP,
  input  logic [DATA_W-1:0]     id_data_REGA,
  input  logic [REG_ADDR_W-1:0] id_rz,
  input  logic [ALU_A_OP_W-1:0] id_alu_a_op,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic                  id_src_a_used,
  input  logic                  id_wb_en,
  input  logic [REG_ADDR_W-1:0] id_wb_addr,
  input  logic                  id_mem_read,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_wb_addr,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_data_T,
  output logic [DATA_W-1:0]     ex_data_SP,
  output logic [DATA_W-1:0]     ex_data_REGA,
  output logic [REG_ADDR_W-1:0] ex_rz,
  output logic [ALU_A_OP_W-1:0] ex_alu_a_op,
  output logic                  ex_fowd_a_en,
  output logic                  ex_fowd_a_src,
  output logic                  ex_wb_en,
  output logic [REG_ADDR_W-1:0] ex_wb_addr,
  output logic                  ex_mem_read,
`ifdef ID_EX_BUBBLE_CNT_EN
  input  logic                  bubble_cnt_clr,
  output logic [15:0]           bubble_cnt,
`endif
  output logic                  id_stall
);

  logic a_reads;
  logic hit_ex;
  logic hit_mem;
  logic fowd_en_d;
  logic fowd_src_d;

  assign a_reads = id_valid & id_src_a_used;
  assign hit_ex  = ex_valid & ex_wb_en & (ex_wb_addr == id_src_a);
  assign hit_mem = mem_wb_en & (mem_wb_addr == id_src_a);

  // Load-use: the EX producer is a load whose data is not available until after MEM.
  assign id_stall = ~rst & a_reads & hit_ex & ex_mem_read;

  // The younger producer (currently in EX, moving to MEM) takes precedence.
  always_comb begin
    fowd_en_d  = 1'b0;
    fowd_src_d = 1'b0;
    if (a_reads && hit_ex) begin
      fowd_en_d  = 1'b1;
      fowd_src_d = 1'b0;
    end else if (a_reads && hit_mem) begin
      fowd_en_d  = 1'b1;
      fowd_src_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_data_T     <= '0;
      ex_data_SP    <= '0;
      ex_data_REGA  <= '0;
      ex_rz         <= '0;
      ex_alu_a_op   <= '0;
      ex_fowd_a_en  <= 1'b0;
      ex_fowd_a_src <= 1'b0;
      ex_wb_en      <= 1'b0;
      ex_wb_addr    <= '0;
      ex_mem_read   <= 1'b0;
    end else if (flush || (!stall_in && id_stall)) begin
      // Bubble: only the qualifying controls drop; payload fields are held.
      ex_valid     <= 1'b0;
      ex_wb_en     <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_fowd_a_en <= 1'b0;
    end else if (!stall_in) begin
      ex_valid      <= id_valid;
      ex_data_T     <= id_data_T;
      ex_data_SP    <= id_data_SP;
      ex_data_REGA  <= id_data_REGA;
      ex_rz         <= id_rz;
      ex_alu_a_op   <= id_alu_a_op;
      ex_fowd_a_en  <= fowd_en_d;
      ex_fowd_a_src <= fowd_src_d;
      ex_wb_en      <= id_wb_en & id_valid;
      ex_wb_addr    <= id_wb_addr;
      ex_mem_read   <= id_mem_read & id_valid;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || bubble_cnt_clr) begin
      bubble_cnt <= '0;
    end else if ((flush || (!stall_in && id_stall)) && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the EX register contents.
module tb_id_ex_stage;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned OW = 2;

  logic clk = 1'b0;
  logic rst, stall_in, flush, id_valid;
  logic [DW-1:0] id_data_T, id_data_SP, id_data_REGA;
  logic [AW-1:0] id_rz, id_src_a, id_wb_addr, mem_wb_addr;
  logic [OW-1:0] id_alu_a_op;
  logic id_src_a_used, id_wb_en, id_mem_read, mem_wb_en;
  logic ex_valid, ex_fowd_a_en, ex_fowd_a_src, ex_wb_en, ex_mem_read, id_stall;
  logic [DW-1:0] ex_data_T, ex_data_SP, ex_data_REGA;
  logic [AW-1:0] ex_rz, ex_wb_addr;
  logic [OW-1:0] ex_alu_a_op;
  logic bubble_cnt_clr;
  logic [15:0] cnt_obs;

  int tests_run = 0;
  int fails = 0;

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .ALU_A_OP_W(OW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_data_T(id_data_T), .id_data_SP(id_data_SP), .id_data_REGA(id_data_REGA),
    .id_rz(id_rz), .id_alu_a_op(id_alu_a_op), .id_src_a(id_src_a),
    .id_src_a_used(id_src_a_used), .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr),
    .id_mem_read(id_mem_read), .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr),
    .ex_valid(ex_valid), .ex_data_T(ex_data_T), .ex_data_SP(ex_data_SP),
    .ex_data_REGA(ex_data_REGA), .ex_rz(ex_rz), .ex_alu_a_op(ex_alu_a_op),
    .ex_fowd_a_en(ex_fowd_a_en), .ex_fowd_a_src(ex_fowd_a_src), .ex_wb_en(ex_wb_en),
    .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt_clr(bubble_cnt_clr), .bubble_cnt(cnt_obs),
`endif
    .id_stall(id_stall)
  );

`ifndef ID_EX_BUBBLE_CNT_EN
  assign cnt_obs = '0;
`endif

  always #5 clk = ~clk;

  // Model of what the EX stage holds, in instruction terms.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] t, sp, rega;
    logic [AW-1:0] rz;
    logic [OW-1:0] op;
    logic          fen, fsrc;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic          mem_read;
  } ex_t;

  ex_t m;
  logic [15:0] m_cnt;

  function automatic ex_t observed();
    ex_t o;
    o = '{ex_valid, ex_data_T, ex_data_SP, ex_data_REGA, ex_rz, ex_alu_a_op,
          ex_fowd_a_en, ex_fowd_a_src, ex_wb_en, ex_wb_addr, ex_mem_read};
    return o;
  endfunction

  // A load-use hazard exists when the instruction in ID needs a value that a load in EX produces.
  function automatic logic model_hazard();
    return !rst && id_valid && id_src_a_used && m.valid && m.wb_en && m.mem_read
           && (m.wb_addr == id_src_a);
  endfunction

  task automatic step();
    ex_t nx;
    logic hz;
    logic [15:0] nc;
    logic bubble;
    hz = model_hazard();
    nx = m;
    bubble = 1'b0;
    if (rst) nx = '0;
    else if (flush) bubble = 1'b1;
    else if (stall_in) nx = m;
    else if (hz) bubble = 1'b1;
    else begin
      nx.valid = id_valid; nx.t = id_data_T; nx.sp = id_data_SP; nx.rega = id_data_REGA;
      nx.rz = id_rz; nx.op = id_alu_a_op;
      nx.wb_en = id_wb_en && id_valid; nx.wb_addr = id_wb_addr;
      nx.mem_read = id_mem_read && id_valid;
      nx.fen = 1'b0; nx.fsrc = 1'b0;
      if (id_valid && id_src_a_used) begin
        if (m.valid && m.wb_en && m.wb_addr == id_src_a) nx.fen = 1'b1;
        else if (mem_wb_en && mem_wb_addr == id_src_a) begin nx.fen = 1'b1; nx.fsrc = 1'b1; end
      end
    end
    if (bubble) begin nx.valid = 0; nx.wb_en = 0; nx.mem_read = 0; nx.fen = 0; end
    nc = m_cnt;
    if (rst || bubble_cnt_clr) nc = '0;
    else if (bubble && m_cnt != 16'hFFFF) nc = m_cnt + 16'd1;
    @(posedge clk);
    m = nx;
    m_cnt = nc;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [DW-1:0] t, input logic [DW-1:0] sp,
                        input logic [DW-1:0] rega, input logic [AW-1:0] rz,
                        input logic [OW-1:0] op, input logic [AW-1:0] src, input logic used,
                        input logic wen, input logic [AW-1:0] wa, input logic mr);
    id_valid = v; id_data_T = t; id_data_SP = sp; id_data_REGA = rega; id_rz = rz;
    id_alu_a_op = op; id_src_a = src; id_src_a_used = used; id_wb_en = wen;
    id_wb_addr = wa; id_mem_read = mr;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; stall_in = 0; mem_wb_en = 1; mem_wb_addr = 4'd3; bubble_cnt_clr = 0;
    set_id(1, 16'h1111, 16'h2222, 16'h3333, 4'd1, 2'd2, 4'd3, 1, 1, 4'd3, 1);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    step(); step();
    tests_run++;
    if (observed() !== ex_t'('0) || id_stall !== 1'b0) begin
      fails++; $display("FAIL reset_regs got=%h stall=%b exp=0", observed(), id_stall);
    end
    rst = 0; mem_wb_en = 0;
  endtask

  task automatic test_plain_load();
    set_id(1, 16'hAAAA, 16'h5555, 16'h1234, 4'd3, 2'd2, 4'd3, 1, 1, 4'd6, 0);
    step();
    tests_run++;
    if (ex_data_REGA !== 16'h1234 || ex_valid !== 1'b1 || ex_fowd_a_en !== 1'b0 ||
        ex_data_T !== 16'hAAAA || ex_data_SP !== 16'h5555 || ex_wb_addr !== 4'd6 ||
        ex_rz !== 4'd3 || ex_alu_a_op !== 2'd2 || ex_mem_read !== 1'b0) begin
      fails++; $display("FAIL plain_load got=%h", observed());
    end
  endtask

  task automatic test_ex_forward();
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd0, 4'd9, 0, 1, 4'd3, 0);
    step();
    // ID reads R3 produced by the EX ALU op; MEM also writes R3 but EX is younger.
    mem_wb_en = 1; mem_wb_addr = 4'd3;
    set_id(1, 16'h0, 16'h0, 16'h7777, 4'd0, 2'd2, 4'd3, 1, 1, 4'd2, 0);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin fails++; $display("FAIL ex_fwd_nostall got=%b exp=0", id_stall); end
    step();
    tests_run++;
    if (ex_fowd_a_en !== 1'b1 || ex_fowd_a_src !== 1'b0) begin
      fails++; $display("FAIL ex_fwd got en=%b src=%b exp en=1 src=0", ex_fowd_a_en, ex_fowd_a_src);
    end
  endtask

  task automatic test_wb_forward();
    mem_wb_en = 1; mem_wb_addr = 4'd5;
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd2, 4'd5, 1, 1, 4'd5, 0);
    step();
    tests_run++;
    if (ex_fowd_a_en !== 1'b1 || ex_fowd_a_src !== 1'b1) begin
      fails++; $display("FAIL wb_fwd got en=%b src=%b exp en=1 src=1", ex_fowd_a_en, ex_fowd_a_src);
    end
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd2, 4'd5, 1, 1, 4'd8, 0);
    step();
    tests_run++;
    if (ex_fowd_a_en !== 1'b1 || ex_fowd_a_src !== 1'b0) begin
      fails++; $display("FAIL younger_wins got en=%b src=%b exp en=1 src=0", ex_fowd_a_en, ex_fowd_a_src);
    end
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd1, 4'd8, 0, 0, 4'd8, 0);
    step();
    tests_run++;
    if (ex_fowd_a_en !== 1'b0 || ex_wb_en !== 1'b0) begin
      fails++; $display("FAIL unused_src got en=%b wb=%b exp 0 0", ex_fowd_a_en, ex_wb_en);
    end
    mem_wb_en = 0;
  endtask

  task automatic test_load_use();
    bubble_cnt_clr = 1;
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd0, 4'd0, 0, 1, 4'd4, 1);
    step();
    bubble_cnt_clr = 0;
    set_id(1, 16'h0, 16'h0, 16'h4444, 4'd0, 2'd2, 4'd4, 1, 1, 4'd1, 0);
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin fails++; $display("FAIL lu_stall got=%b exp=1", id_stall); end
    step();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || ex_mem_read !== 1'b0) begin
      fails++; $display("FAIL lu_bubble got=%h", observed());
    end
    mem_wb_en = 1; mem_wb_addr = 4'd4;
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin fails++; $display("FAIL lu_one_cycle got=%b exp=0", id_stall); end
    step();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_fowd_a_en !== 1'b1 || ex_fowd_a_src !== 1'b1 || ex_data_REGA !== 16'h4444) begin
      fails++; $display("FAIL lu_capture got=%h", observed());
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    tests_run++;
    if (cnt_obs !== 16'd1) begin fails++; $display("FAIL lu_cnt got=%0d exp=1", cnt_obs); end
`endif
    mem_wb_en = 0;
  endtask

  task automatic test_flush_stall();
    ex_t held;
    set_id(1, 16'h0, 16'h0, 16'hBEEF, 4'd0, 2'd0, 4'd0, 0, 1, 4'd1, 0);
    step();
    flush = 1; stall_in = 1;
    step();
    tests_run++;
    if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_over_stall got=%b exp=0", ex_valid); end
    flush = 0; stall_in = 0;
    set_id(1, 16'h1357, 16'h2468, 16'hCAFE, 4'd5, 2'd1, 4'd9, 0, 1, 4'd7, 1);
    step();
    held = '{1'b1, 16'h1357, 16'h2468, 16'hCAFE, 4'd5, 2'd1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1};
    stall_in = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      set_id(1, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom),
             4'd2, 1, 1, 4'($urandom), 0);
      step();
      tests_run++;
      if (observed() !== held) begin fails++; $display("FAIL stall_hold%0d got=%h exp=%h", i, observed(), held); end
    end
    // EX holds a load to R7; ID reading R7 raises id_stall while stall_in holds everything.
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd2, 4'd7, 1, 0, 4'd0, 0);
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin fails++; $display("FAIL stall_and_hazard got=%b exp=1", id_stall); end
    step();
    tests_run++;
    if (observed() !== held) begin fails++; $display("FAIL stall_over_hazard got=%h exp=%h", observed(), held); end
    stall_in = 0; flush = 1;
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin fails++; $display("FAIL flush_hazard_stall got=%b exp=1", id_stall); end
    step();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || ex_data_REGA !== 16'hCAFE) begin
      fails++; $display("FAIL flush_hazard got=%h", observed());
    end
    flush = 0;
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd0, 4'd0, 0, 1, 4'd4, 1);
    step();
    set_id(1, 16'h0, 16'h0, 16'h0, 4'd0, 2'd2, 4'd4, 1, 0, 4'd0, 0);
    rst = 1;
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got=%b exp=0", id_stall); end
    step();
    tests_run++;
    if (observed() !== ex_t'('0)) begin fails++; $display("FAIL rst_mid_regs got=%h exp=0", observed()); end
    rst = 0;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 600; i++) begin
      rst = ($urandom % 40) == 0;
      flush = ($urandom % 8) == 0;
      stall_in = ($urandom % 6) == 0;
      bubble_cnt_clr = ($urandom % 50) == 0;
      mem_wb_en = 1'($urandom);
      mem_wb_addr = 4'($urandom % 4);
      set_id(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
             2'($urandom), 4'($urandom % 4), 1'($urandom), 1'($urandom), 4'($urandom % 4),
             1'($urandom));
      #1;
      tests_run++;
      if (id_stall !== model_hazard()) begin
        fails++; $display("FAIL rnd_stall%0d got=%b exp=%b", i, id_stall, model_hazard());
      end
      step();
      tests_run++;
      if (observed() !== m) begin fails++; $display("FAIL rnd_regs%0d got=%h exp=%h", i, observed(), m); end
`ifdef ID_EX_BUBBLE_CNT_EN
      tests_run++;
      if (cnt_obs !== m_cnt) begin fails++; $display("FAIL rnd_cnt%0d got=%0d exp=%0d", i, cnt_obs, m_cnt); end
`endif
    end
    rst = 0; flush = 0; stall_in = 0; bubble_cnt_clr = 0;
  endtask

  initial begin
    m = '0;
    m_cnt = '0;
    test_reset();
    test_plain_load();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_flush_stall();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode (ID) and execute (EX).
- Latches the operand candidates and the ALU-A select code that the EX-stage operand-A mux consumes.
- Pre-computes the operand-A forwarding enable and source one stage early.
- Detects load-use hazards, then stalls ID and inserts a bubble into EX.

Parameters:
DATA_W, 16, datapath width (T, SP, REGA values)
REG_ADDR_W, 4, register-file address width
ALU_A_OP_W, 2, width of ALU-A select code

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
stall_in  in  1  downstream stall: hold all EX outputs
flush  in  1  branch/exception flush: EX becomes a bubble
id_valid  in  1  ID holds a real instruction
id_data_T  in  DATA_W  T register value
id_data_SP  in  DATA_W  SP value
id_data_REGA  in  DATA_W  register-file read port A
id_rz  in  REG_ADDR_W  RZ field / 3-bit immediate, zero-extended
id_alu_a_op  in  ALU_A_OP_W  ALU-A select code
id_src_a  in  REG_ADDR_W  architectural source register of operand A
id_src_a_used  in  1  operand A reads id_src_a (op is REGA)
id_wb_en  in  1  instruction writes a register
id_wb_addr  in  REG_ADDR_W  destination register
id_mem_read  in  1  instruction is a load
mem_wb_en  in  1  MEM-stage instruction writes a register
mem_wb_addr  in  REG_ADDR_W  MEM-stage destination
ex_valid  out  1  EX holds a real instruction
ex_data_T / ex_data_SP / ex_data_REGA  out  DATA_W each  latched operands
ex_rz  out  REG_ADDR_W  latched RZ
ex_alu_a_op  out  ALU_A_OP_W  latched select
ex_fowd_a_en  out  1  operand A must take the forwarded value
ex_fowd_a_src  out  1  0 = MEM-stage result, 1 = WB-stage result
ex_wb_en, ex_wb_addr, ex_mem_read  out  1/REG_ADDR_W/1  latched control
id_stall  out  1  combinational: hold PC and IF/ID this cycle

Behaviour:
- Reset (sync, rst=1 at posedge): every output register goes to 0, including ex_valid=0 and ex_fowd_a_en=0. id_stall=0 while rst=1.
- Load-use hazard (combinational): id_stall = id_valid & id_src_a_used & ex_valid & ex_mem_read & ex_wb_en & (ex_wb_addr==id_src_a).
- Register update priority at posedge (highest first):
  1. rst: clear all registers.
  2. flush: bubble. ex_valid, ex_wb_en, ex_mem_read and ex_fowd_a_en go to 0; data fields are don't-care and are held.
  3. stall_in: hold every register unchanged.
  4. id_stall: bubble, same as flush.
  5. Otherwise: load all ID fields; ex_valid = id_valid; ex_wb_en/ex_mem_read are gated by id_valid.
- Forwarding, computed only on the load case (5). Let hitEX = ex_valid & ex_wb_en & ex_wb_addr==id_src_a. The current EX instruction moves to MEM next cycle.
  - hitEX & id_src_a_used & id_valid -> ex_fowd_a_en=1, src=0.
  - Else mem_wb_en & mem_wb_addr==id_src_a & id_src_a_used & id_valid -> en=1, src=1.
  - Else en=0, src=0.
  - The younger producer (EX) always wins.
- Latency: ID fields appear on EX outputs exactly 1 cycle after capture.
- A load-use hazard stalls exactly 1 cycle. Next cycle the load is in MEM and EX holds a bubble, so no second stall occurs; forwarding src=1 is selected.
- flush and id_stall together: flush wins; id_stall is still asserted in that cycle.
- stall_in and id_stall together: hold; id_stall remains asserted.
- Reset mid-stall: registers clear and id_stall deasserts in the same cycle.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined:
  - Adds output bubble_cnt (16 bits) and input bubble_cnt_clr (1 bit).
  - bubble_cnt increments on each posedge where a bubble is inserted by id_stall or flush, but not by stall_in.
  - Saturates at 0xFFFF.
  - Clears on rst or bubble_cnt_clr; clear has priority over increment.
- When undefined: the ports and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> all outputs 0, id_stall=0.
- Plain load: id_valid=1, REGA=0x1234, op=REGA, src=R3, no hazards -> next cycle ex_data_REGA=0x1234, ex_valid=1, ex_fowd_a_en=0.
- EX forward: EX holds a non-load writing R3; ID reads R3 -> next cycle ex_fowd_a_en=1, src=0.
- WB forward: mem_wb_en=1, mem_wb_addr=R5; ID reads R5; EX writes R2 -> en=1, src=1. With EX also writing R5 -> src=0.
- Load-use: EX is a load to R4; ID reads R4 -> id_stall=1 for exactly 1 cycle, then ex_valid=0 (bubble). Next capture: en=1, src=1; with the counter enabled, bubble_cnt=1.
- Flush vs stall: flush=1 and stall_in=1 together -> ex_valid=0 next cycle. stall_in alone for 3 cycles -> outputs held bit-exact.
